// File: rtl/dmem_responder.sv
// Word data memory behind a single-outstanding valid/ready request/response pair.
// Latency: rsp_valid rises WAIT_STATES+1 edges after the accepting edge (counting that edge as the first).
// Backpressure: req_ready is low from acceptance until the response handshake; RESP holds while rsp_ready=0.
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int LP_DEPTH = 2 ** (DM_ADDRESS - 2);
    localparam int LP_LANES = DATA_W / 8;
    // Counter preload: BUSY lasts WAIT_STATES cycles, leaving when the counter reads zero.
    localparam logic [3:0] LP_CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_req_ready;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [LP_LANES-1:0]   r_wstrb;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;
    logic [DATA_W-1:0]     r_mem [0:LP_DEPTH-1];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_src_we;
    logic [31:0]           w_src_addr;
    logic [LP_LANES-1:0]   w_src_wstrb;
    logic [DATA_W-1:0]     w_src_wdata;
    logic                  w_err;
    logic [DM_ADDRESS-3:0] w_idx;

    assign req_ready = r_req_ready;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // Next-state logic plus commit-source selection; with zero wait states the
    // commit happens on the accepting edge, so the live request is used directly.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = req_valid && r_req_ready;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_commit    = (r_state != ST_RESP) && (w_state_nxt == ST_RESP);
        w_src_we    = (r_state == ST_IDLE) ? req_we    : r_we;
        w_src_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
        w_src_wstrb = (r_state == ST_IDLE) ? req_wstrb : r_wstrb;
        w_src_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
        w_err       = (w_src_addr[1:0] != 2'b00) || (w_src_addr[31:DM_ADDRESS] != '0);
        w_idx       = w_src_addr[DM_ADDRESS-1:2];
    end

    // State, request capture, wait counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wstrb <= req_wstrb;
                r_wdata <= req_wdata;
                r_cnt   <= LP_CNT_LOAD;
            end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (!w_err && !w_src_we) ? r_mem[w_idx] : '0;
            end else if ((r_state == ST_RESP) && rsp_ready) begin
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
        end
    end

    // Storage write: only strobed lanes of an in-range aligned write change.
    always_ff @(posedge clk) begin
        if (w_commit && !w_err && w_src_we) begin
            for (int i = 0; i < LP_LANES; i++) begin
                if (w_src_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_src_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: table of word requests against a WAIT_STATES=2 instance,
// hand sequences for backpressure and mid-operation reset, and a streaming
// check against a WAIT_STATES=0 instance.
module tb_dmem_responder;

    localparam int WAIT_A = 2;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [3:0]  z_req_wstrb;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(WAIT_A)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wstrb(z_req_wstrb), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete request on the WAIT_STATES=2 instance with rsp_ready high.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wstrb = strb; req_wdata = wd;
        rsp_ready = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
            req_valid = 1'b0;
        end while (!rsp_valid && n < 20);
        chk({tag, ":latency"}, 32'(n), 32'(WAIT_A + 1));
        chk({tag, ":rdata"}, rsp_rdata, exp_rd);
        chk({tag, ":err"}, 32'(rsp_err), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, ":valid_after_hs"}, 32'(rsp_valid), 32'd0);
        chk({tag, ":ready_after_hs"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic        s_we   [6];
        logic [3:0]  s_strb [6];
        logic [31:0] s_wd   [6];
        logic [31:0] s_exp  [6];
        int acc_cyc [6];
        int idx, rix, prev_cyc;
        logic will;

        vecs[0]  = '{1'b1, 32'h010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h010, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h010, 4'h4, 32'h00AA0000, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h010, 4'h0, 32'h0,        32'hDEAABEEF, 1'b0};
        vecs[4]  = '{1'b1, 32'h010, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'h010, 4'h0, 32'h0,        32'hDEAABEEF, 1'b0};
        vecs[6]  = '{1'b1, 32'h000, 4'hF, 32'h11223344, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 32'h012, 4'h0, 32'h0,        32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'h200, 4'hF, 32'h99999999, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h000, 4'h0, 32'h0,        32'h11223344, 1'b0};
        vecs[10] = '{1'b1, 32'h1FC, 4'hF, 32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h1FC, 4'h0, 32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[12] = '{1'b1, 32'h80000020, 4'hF, 32'h0BADF00D, 32'h0,   1'b1};
        vecs[13] = '{1'b1, 32'h020, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0};

        req_valid = 0; req_we = 0; req_addr = 0; req_wstrb = 0; req_wdata = 0; rsp_ready = 1;
        z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_wstrb = 0; z_req_wdata = 0;
        z_rsp_ready = 1;

        // Reset values
        rst_n = 1'b0;
        #23;
        chk("rst:req_ready", 32'(req_ready), 32'd0);
        chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst:rsp_rdata", rsp_rdata, 32'd0);
        chk("rst:rsp_err", 32'(rsp_err), 32'd0);
        chk("rst:z_req_ready", 32'(z_req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst:req_ready", 32'(req_ready), 32'd1);
        chk("post_rst:rsp_valid", 32'(rsp_valid), 32'd0);

        // Table-driven requests
        for (int i = 0; i < 14; i++) begin
            run_req(vecs[i].we, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Backpressure: response held for 5 cycles while a competing request is ignored
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h010; req_wstrb = 4'h0; rsp_ready = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            req_valid = 1'b0;
        end while (!rsp_valid && n < 20);
        chk("bp:latency", 32'(n), 32'(WAIT_A + 1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h010; req_wstrb = 4'hF; req_wdata = 32'h0;
            @(posedge clk); #1;
            chk($sformatf("bp%0d:rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d:rsp_rdata", k), rsp_rdata, 32'hDEAABEEF);
            chk($sformatf("bp%0d:req_ready", k), 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp:valid_after_hs", 32'(rsp_valid), 32'd0);
        chk("bp:ready_after_hs", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp:single_hs", 32'(rsp_valid), 32'd0);
        run_req(1'b0, 32'h010, 4'h0, 32'h0, 32'hDEAABEEF, 1'b0, "bp_readback");

        // Reset during BUSY drops the uncommitted write
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h020; req_wstrb = 4'hF; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid:busy_ready", 32'(req_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid:req_ready", 32'(req_ready), 32'd0);
        chk("mid:rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid:rsp_err", 32'(rsp_err), 32'd0);
        chk("mid:rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_req(1'b0, 32'h020, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, "mid_readback");

        // Zero wait states, rsp_ready tied high: alternating write/read of 0x7C
        s_we   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        s_strb = '{4'hF, 4'h0, 4'h3, 4'h0, 4'hF, 4'h0};
        s_wd   = '{32'h11111111, 32'h0, 32'h22222222, 32'h0, 32'h33333333, 32'h0};
        s_exp  = '{32'h0, 32'h11111111, 32'h0, 32'h11112222, 32'h0, 32'h33333333};
        idx = 0; rix = 0; prev_cyc = 0;
        for (int c = 0; c < 40 && rix < 6; c++) begin
            @(negedge clk);
            if (idx < 6) begin
                z_req_valid = 1'b1; z_req_we = s_we[idx]; z_req_addr = 32'h7C;
                z_req_wstrb = s_strb[idx]; z_req_wdata = s_wd[idx];
            end else begin
                z_req_valid = 1'b0;
            end
            will = z_req_valid && z_req_ready;
            @(posedge clk); #1;
            if (will) begin
                acc_cyc[idx] = c;
                idx++;
            end
            if (z_rsp_valid && rix < idx) begin
                chk($sformatf("z%0d:rdata", rix), z_rsp_rdata, s_exp[rix]);
                chk($sformatf("z%0d:err", rix), 32'(z_rsp_err), 32'd0);
                chk($sformatf("z%0d:latency", rix), 32'(c - acc_cyc[rix] + 1), 32'd1);
                if (rix > 0) begin
                    chk($sformatf("z%0d:period", rix), 32'(c - prev_cyc), 32'd2);
                end
                prev_cyc = c;
                rix++;
            end
        end
        z_req_valid = 1'b0;
        chk("z:responses", 32'(rix), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
